dmem_arbiter: RTL

//  Two-port arbiter/sequencer for the 256-word data memory. Port 0 = pipeline MEM stage,

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_arbiter_rr_arb2.sv | 21 ++
 rtl/dmem_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, port indices
// and the default memory depth.
package dmem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int PORT_CPU       = 0;
    localparam int PORT_DBG       = 1;
    localparam int DEPTH_LOG2_DEF = 8;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; under contention
// the port that did not win last time is granted.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == 1'(PORT_DBG)) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the 256-word data memory. Serialises
// MEM-stage and loader accesses, one access every two cycles, tagged responses.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_write,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    output state_t            dbg_state
);

    // Handshake: a request on port p is accepted at the rising edge where
    // req_valid[p] & req_ready[p]; the requester holds write/addr/wdata stable
    // until then. Responses are single-cycle rsp_valid pulses with no backpressure.

    state_t            state;
    logic              last_grant;
    logic              cmd_port;
    logic              cmd_write;
    logic              cmd_in_range;

    logic [1:0]        grant;
    logic [1:0]        hs;
    logic              hs_port;
    logic              sel_write;
    logic              sel_in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Ready is forced low while reset is held, even though state already reads IDLE.
    always_comb begin
        req_ready = 2'b00;
        if (!rst && state == IDLE) begin
            req_ready = grant;
        end
    end

    assign hs           = req_valid & req_ready;
    assign hs_port      = hs[1];
    assign sel_write    = hs_port ? req_write[1] : req_write[0];
    assign sel_addr     = hs_port ? req_addr1 : req_addr0;
    assign sel_wdata    = hs_port ? req_wdata1 : req_wdata0;
    assign sel_in_range = (sel_addr[ADDR_W-1:DEPTH_LOG2] == '0);
    assign dbg_state    = state;

    // mem_addr/mem_wdata double as the latched command; strobes are registered
    // so mem_write is high for exactly the ACCESS cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'(PORT_DBG);
            cmd_port     <= 1'b0;
            cmd_write    <= 1'b0;
            cmd_in_range <= 1'b0;
            rsp_valid    <= 2'b00;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_write    <= 1'b0;
            mem_read     <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            case (state)
                IDLE: begin
                    if (|hs) begin
                        cmd_port     <= hs_port;
                        cmd_write    <= sel_write;
                        cmd_in_range <= sel_in_range;
                        last_grant   <= hs_port;
                        mem_addr     <= sel_addr;
                        mem_wdata    <= sel_wdata;
                        mem_write    <= sel_write & sel_in_range;
                        mem_read     <= ~sel_write & sel_in_range;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_write <= 1'b0;
                    mem_read  <= 1'b0;
                    rsp_rdata <= (!cmd_write && cmd_in_range) ? mem_rdata : '0;
                    rsp_err   <= ~cmd_in_range;
                    rsp_valid <= (cmd_port == 1'(PORT_CPU)) ? 2'b01 : 2'b10;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_strobe_exclusive : assert property (@(posedge clk) disable iff (rst) !(mem_write && mem_read));

endmodule
